// File: rtl/bsg_profiler_counter_dump_if.sv
// rtl/bsg_profiler_counter_dump_if.sv - dump request and entry handshake bundle for the profiler counter dump
interface bsg_profiler_counter_dump_if #(
  parameter int width_p    = 32,
  parameter int id_width_p = 5
);
  logic                  dump_v_i;
  logic                  dump_ready_o;
  logic                  v_o;
  logic [width_p-1:0]    data_o;
  logic [id_width_p-1:0] id_o;
  logic                  last_o;
  logic                  yumi_i;

  // Counter block side: accepts dump requests, presents entries
  modport master (
    input  dump_v_i,
    input  yumi_i,
    output dump_ready_o,
    output v_o,
    output data_o,
    output id_o,
    output last_o
  );

  // Consumer side: requests dumps, takes entries
  modport slave (
    output dump_v_i,
    output yumi_i,
    input  dump_ready_o,
    input  v_o,
    input  data_o,
    input  id_o,
    input  last_o
  );
endinterface

// File: rtl/bsg_profiler_counter_dump.sv
// rtl/bsg_profiler_counter_dump.sv - saturating profiling counters with read-and-clear scan-out
module bsg_profiler_counter_dump #(
  parameter int els_p       = 32,
  parameter int width_p     = 32,
  parameter int inc_width_p = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [els_p*inc_width_p-1:0] countme_i,
  input  logic                         clear_i,
  bsg_profiler_counter_dump_if.master  dump_if
);

  localparam int id_w_lp  = (els_p > 1) ? $clog2(els_p) : 1;
  // One extra bit over the wider operand so the true sum never wraps before clamping
  localparam int sum_w_lp = ((width_p > inc_width_p) ? width_p : inc_width_p) + 1;
  localparam logic [id_w_lp-1:0]  last_idx_lp = id_w_lp'(els_p - 1);
  localparam logic [sum_w_lp-1:0] max_cnt_lp  = sum_w_lp'({width_p{1'b1}});

  typedef enum logic {IDLE_S, SCAN_S} state_e;

  state_e               state_q, state_d;
  logic [id_w_lp-1:0]   idx_q, idx_d;
  logic [width_p-1:0]   cnt_q [els_p];
  logic [width_p-1:0]   cnt_d [els_p];
  logic                 yumi_accept;

  // State and scan index register; reset aborts any scan in progress
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE_S;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: dump requests only matter when idle, yumi only when scanning
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    yumi_accept = 1'b0;
    case (state_q)
      IDLE_S: begin
        if (dump_if.dump_v_i) begin
          state_d = SCAN_S;
          idx_d   = '0;
        end
      end
      SCAN_S: begin
        if (dump_if.yumi_i) begin
          yumi_accept = 1'b1;
          if (idx_q == last_idx_lp) begin
            state_d = IDLE_S;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE_S;
        idx_d   = '0;
      end
    endcase
  end

  // Counter next values: clear wins, a consumed entry restarts from this cycle's increment
  always_comb begin
    logic [inc_width_p-1:0] inc_v;
    logic [width_p-1:0]     base_v;
    logic [sum_w_lp-1:0]    sum_v;
    inc_v  = '0;
    base_v = '0;
    sum_v  = '0;
    for (int i = 0; i < els_p; i++) begin
      inc_v  = countme_i[i*inc_width_p +: inc_width_p];
      base_v = (yumi_accept && (idx_q == id_w_lp'(i))) ? '0 : cnt_q[i];
      sum_v  = sum_w_lp'(base_v) + sum_w_lp'(inc_v);
      if (clear_i) begin
        cnt_d[i] = '0;
      end else if (sum_v > max_cnt_lp) begin
        cnt_d[i] = {width_p{1'b1}};
      end else begin
        cnt_d[i] = sum_v[width_p-1:0];
      end
    end
  end

  // Counter storage
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < els_p; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Entry presentation is purely a function of current state, so reset clears it at once
  assign dump_if.dump_ready_o = (state_q == IDLE_S);
  assign dump_if.v_o          = (state_q == SCAN_S);
  assign dump_if.id_o         = (state_q == SCAN_S) ? idx_q : '0;
  assign dump_if.data_o       = (state_q == SCAN_S) ? cnt_q[idx_q] : '0;
  assign dump_if.last_o       = (state_q == SCAN_S) && (idx_q == last_idx_lp);

endmodule

// File: doc/bsg_profiler_counter_dump.md
BSG_PROFILER_COUNTER_DUMP -- requirements
Module: bsg_profiler_counter_dump

Interface
REQ-001 SHALL have parameter els_p, default 32, number of profiling counters.
REQ-002 SHALL have parameter width_p, default 32, width of each counter in bits.
REQ-003 SHALL have parameter inc_width_p, default 16, width of each per-counter increment.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-005 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n_i  input  1  asynchronous, active-low reset.
REQ-007 countme_i  input  els_p*inc_width_p  packed increments; slice i feeds counter i every cycle.
REQ-008 clear_i  input  1  synchronous clear of all counters.
REQ-009 dump_v_i  input  1  request to start a scan-out of all counters.
REQ-010 dump_ready_o  output  1  high when idle, meaning a dump request will be accepted.
REQ-011 v_o  output  1  a counter entry is presented.
REQ-012 data_o  output  width_p  value of the counter currently presented.
REQ-013 id_o  output  max(1,clog2(els_p))  index of the counter presented.
REQ-014 last_o  output  1  the presented entry is id els_p-1.
REQ-015 yumi_i  input  1  consumer takes the presented entry; legal only when v_o=1.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and SCAN, with a scan index idx_r.
REQ-017 In IDLE: dump_ready_o=1, v_o=0; on dump_v_i=1, move to SCAN with idx_r=0 next cycle.
REQ-018 In SCAN: dump_ready_o=0, v_o=1, id_o=idx_r, data_o=counter[idx_r], last_o=(idx_r==els_p-1).
REQ-019 In SCAN, dump_v_i SHALL be ignored, including in the cycle of the final yumi.
REQ-020 On a SCAN yumi with idx_r<els_p-1, idx_r SHALL increment; with idx_r==els_p-1, next state is IDLE.
REQ-021 With yumi_i=0, SCAN SHALL hold idx_r and data_o SHALL track the live counter value, which may change while stalled.
REQ-022 Each cycle without clear or read, counter[i] <= sat(counter[i] + countme_i[i]).
REQ-023 sat(x) SHALL clamp to 2^width_p-1 if the true sum exceeds it, with no wrap-around; the increment is zero-extended.
REQ-024 Read-and-clear: on the yumi cycle, counter[idx_r] <= countme_i[idx_r], so that cycle's increment is not lost and is not included in data_o.
REQ-025 clear_i=1 SHALL set all counters to 0, discard that cycle's increments, and take priority over read-and-clear.
REQ-026 clear_i SHALL NOT affect the FSM, idx_r, or the handshake; a yumi in the same cycle still advances.
REQ-027 yumi_i=1 while v_o=0 SHALL be ignored.
REQ-028 Entry presentation SHALL have zero latency: v_o rises the cycle after dump_v_i is accepted, and a full scan with yumi_i held high takes exactly els_p cycles.

Reset
REQ-029 reset_n_i=0 SHALL immediately, without waiting for a clock edge, force state IDLE, idx_r=0, all counters 0, v_o=0, last_o=0, id_o=0, data_o=0 and dump_ready_o=1.
REQ-030 Reset asserted mid-scan SHALL abort the scan with no further entries presented; the first dump after release starts at id 0.
REQ-031 The first rising edge with reset_n_i=1 SHALL already accumulate countme_i and accept dump_v_i.

Verification
(All scenarios use els_p=4, width_p=8, inc_width_p=4.)
REQ-032 Slice1=3 for 10 cycles, others 0, then dump with yumi_i=1 -> entries (id,data)=(0,0),(1,30),(2,0),(3,0) on 4 consecutive cycles; last_o only with id 3; dump_ready_o=1 next cycle.
REQ-033 Slice0=15 for 20 cycles, then dump -> id 0 data=255 (saturated, not 44); counter0 restarts from that cycle's increment.
REQ-034 Slice2=1 every cycle; stall yumi_i=0 at id 2 for 5 cycles -> data_o rises by 1 per cycle; on accept the value shown is reported and counter2 = 1 the next cycle.
REQ-035 Pulse dump_v_i during SCAN and in the final-yumi cycle -> no restart; exactly 4 entries; IDLE afterwards.
REQ-036 Assert reset_n_i=0 asynchronously while at id 2 -> v_o=0 and dump_ready_o=1 immediately; after release, a dump shows all data=0 plus post-reset increments.
REQ-037 clear_i=1 in the same cycle as a yumi at id 1 -> all counters 0 next cycle; scan continues at id 2 with data reflecting only post-clear increments.
